// File: rtl/ps2_rx_fifo_if.sv
// Bus bundle for ps2_rx_fifo: PS/2 pins, receive control and FIFO read side.
// The testbench or parent drives through master; the receiver uses slave.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          ps2c;
    logic          ps2d;
    logic          rx_en;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          rx_done_tick;
    logic          parity_err;
    logic          frame_err;
    logic          overflow;

    modport master (
        output ps2c, ps2d, rx_en, rd_en, clr_err,
        input  dout, empty, full, count, rx_done_tick, parity_err, frame_err, overflow
    );

    modport slave (
        input  ps2c, ps2d, rx_en, rd_en, clr_err,
        output dout, empty, full, count, rx_done_tick, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: glitch-filtered clock, start/parity/stop checking,
// inter-edge watchdog and a first-word-fall-through receive FIFO with sticky error flags.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic           clk,
    input  logic           reset,
    ps2_rx_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fc;
    logic                  w_fall;

    logic [1:0]            r_state;
    logic [3:0]            r_bitcnt;
    logic [WW-1:0]         r_wd;
    logic [10:0]           r_shift;
    logic                  w_timeout;

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_empty;
    logic                  w_full;

    logic                  w_check;
    logic                  w_frame_bad;
    logic                  w_par_bad;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf;

    logic                  r_par_err;
    logic                  r_frame_err;
    logic                  r_overflow;

    // Synchronizers and clock glitch filter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_sync <= '0;
            r_d_sync <= '0;
            r_filt   <= '0;
            r_fc     <= 1'b0;
        end else begin
            r_c_sync <= {r_c_sync[0], bus.ps2c};
            r_d_sync <= {r_d_sync[0], bus.ps2d};
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_c_sync[1]};
            if (r_filt == '1)
                r_fc <= 1'b1;
            else if (r_filt == '0)
                r_fc <= 1'b0;
        end
    end

    // The edge is flagged in the same cycle the filter first reads all-zero,
    // i.e. the cycle before r_fc itself drops.
    assign w_fall = r_fc && (r_filt == '0);

    assign w_timeout = (r_state == S_DATA) && !w_fall && (r_wd == WD_MAX);

    // Frame FSM; bits shift in at the MSB so start lands in [0] and stop in [10]
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_wd     <= '0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall && bus.rx_en) begin
                        r_shift  <= {r_d_sync[1], r_shift[10:1]};
                        r_bitcnt <= 4'd10;
                        r_wd     <= '0;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        r_shift  <= {r_d_sync[1], r_shift[10:1]};
                        r_bitcnt <= r_bitcnt - 4'd1;
                        r_wd     <= '0;
                        if (r_bitcnt == 4'd1)
                            r_state <= S_CHECK;
                    end else if (w_timeout) begin
                        r_wd    <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_CHECK: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_check     = (r_state == S_CHECK);
    assign w_frame_bad = r_shift[0] || !r_shift[10];
    assign w_par_bad   = !(^r_shift[9:1]);
    assign w_valid     = w_check && !w_frame_bad && !w_par_bad;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = bus.rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push  = w_valid && (!w_full || w_pop);
    assign w_ovf   = w_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= r_shift[8:1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle wins over clr_err
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_check && !w_frame_bad && w_par_bad)
                r_par_err <= 1'b1;
            else if (bus.clr_err)
                r_par_err <= 1'b0;

            if ((w_check && w_frame_bad) || w_timeout)
                r_frame_err <= 1'b1;
            else if (bus.clr_err)
                r_frame_err <= 1'b0;

            if (w_ovf)
                r_overflow <= 1'b1;
            else if (bus.clr_err)
                r_overflow <= 1'b0;
        end
    end

    assign bus.dout         = w_empty ? 8'h00 : r_mem[r_rptr];
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.count        = r_count;
    assign bus.rx_done_tick = w_push;
    assign bus.parity_err   = r_par_err;
    assign bus.frame_err    = r_frame_err;
    assign bus.overflow     = r_overflow;
endmodule
